cacheline_adapter: RTL and testbench

- Memory-side responder for the cache line interface (cache `mmem_r`/`mmem_w`, `mmem_addr`, 256-bit line data, one-cycle `mmem_status` completion).
- Accepts one full-line read (I-cache fill) or line write (D-cache writeback) per transaction.
- Executes it as a 4-beat, 64-bit burst to the external memory port.
- Sits between the cache arbiter and the physical memory model.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cacheline_adapter.sv | 127 ++++++++++++
 tb/tb_cacheline_adapter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths and state encoding for the cache line adapter.
package cache_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BEATS       = LINE_W / BEAT_W;
  localparam int unsigned CNT_W       = $clog2(BEATS);
  localparam int unsigned OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Cache line adapter: turns one 256-bit line read/write into a 4-beat,
// 64-bit burst on the memory port and returns a one-cycle line_resp.
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);

  adapter_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              resp_q, resp_d;

  // State and output registers; reset discards any partial burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state logic; strobes are computed one cycle ahead so they come out registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    resp_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Writeback takes priority over fill when both are requested.
        if (line_write) begin
          state_d = WR;
          wr_d    = 1'b1;
          addr_d  = line_addr & ~OFF_MASK;
          wbuf_d  = line_wdata;
          cnt_d   = '0;
        end else if (line_read) begin
          state_d = RD;
          rd_d    = 1'b1;
          addr_d  = line_addr & ~OFF_MASK;
          cnt_d   = '0;
        end
      end

      RD: begin
        rd_d = 1'b1;
        if (mem_resp) begin
          rdata_d[BEAT_W*cnt_q +: BEAT_W] = mem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            rd_d    = 1'b0;
            resp_d  = 1'b1;
          end
        end
      end

      WR: begin
        wr_d = 1'b1;
        if (mem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            wr_d    = 1'b0;
            resp_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign line_rdata = rdata_q;
  assign line_resp  = resp_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wbuf_q[BEAT_W*cnt_q +: BEAT_W];

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter.
module tb_cacheline_adapter;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              line_read, line_write;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  int n_assert = 0;
  int n_fail   = 0;
  int resp_cnt = 0;

  logic [BEAT_W-1:0] rb [4];
  logic [BEAT_W-1:0] fb [4];
  logic [BEAT_W-1:0] wb [4];
  logic [LINE_W-1:0] exp_line;
  logic [LINE_W-1:0] fresh_line;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .line_read  (line_read),
    .line_write (line_write),
    .line_addr  (line_addr),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_resp  (line_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  always #5 clk = ~clk;

  // Counts line_resp pulses, sampled mid-cycle.
  always @(negedge clk) if (line_resp === 1'b1) resp_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rb[0] = 64'h1111_1111_1111_1111; rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333; rb[3] = 64'h4444_4444_4444_4444;
    fb[0] = 64'h0123_4567_89AB_CDEF; fb[1] = 64'hFEDC_BA98_7654_3210;
    fb[2] = 64'h5555_6666_7777_8888; fb[3] = 64'h9999_AAAA_BBBB_CCCC;
    wb[0] = 64'hAAAA_AAAA_AAAA_AAAA; wb[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wb[2] = 64'hCCCC_CCCC_CCCC_CCCC; wb[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    exp_line   = {rb[3], rb[2], rb[1], rb[0]};
    fresh_line = {fb[3], fb[2], fb[1], fb[0]};

    rst = 1'b1; line_read = 1'b0; line_write = 1'b0;
    line_addr = '0; line_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_mem_read",  256'(mem_read),  256'(0));
    chk("rst_mem_write", 256'(mem_write), 256'(0));
    chk("rst_line_resp", 256'(line_resp), 256'(0));
    chk("rst_mem_addr",  256'(mem_addr),  256'(0));
    chk("rst_line_rdata", line_rdata, 256'(0));
    rst = 1'b0;
    tick();

    // Read, zero-wait memory
    line_read = 1'b1; line_addr = 32'h0000_1234;
    tick();
    chk("rd0_mem_read", 256'(mem_read), 256'(1));
    chk("rd0_mem_addr", 256'(mem_addr), 256'(32'h0000_1220));
    for (int b = 0; b < 4; b++) begin
      chk("rd0_no_resp", 256'(line_resp), 256'(0));
      mem_rdata = rb[b]; mem_resp = 1'b1;
      tick();
    end
    chk("rd0_line_resp", 256'(line_resp), 256'(1));
    chk("rd0_mem_read_drop", 256'(mem_read), 256'(0));
    chk("rd0_line_rdata", line_rdata, exp_line);
    line_read = 1'b0; mem_resp = 1'b0;
    tick();
    chk("rd0_resp_one_cycle", 256'(line_resp), 256'(0));
    tick();

    // Read with two wait states before each beat
    line_read = 1'b1; line_addr = 32'h0000_1234;
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        chk("rdw_mem_read", 256'(mem_read), 256'(1));
        chk("rdw_no_resp", 256'(line_resp), 256'(0));
        mem_resp  = (w == 2);
        mem_rdata = (w == 2) ? rb[b] : 64'hDEAD_BEEF_0BAD_F00D;
        tick();
      end
    end
    chk("rdw_line_resp", 256'(line_resp), 256'(1));
    chk("rdw_line_rdata", line_rdata, exp_line);
    line_read = 1'b0; mem_resp = 1'b0;
    tick(); tick();

    // Write; inputs changed after acceptance must not matter
    resp_cnt = 0;
    line_write = 1'b1; line_addr = 32'h8000_003F;
    line_wdata = {wb[3], wb[2], wb[1], wb[0]};
    tick();
    line_addr = 32'hFFFF_FFFF; line_wdata = '1;
    chk("wr_mem_write", 256'(mem_write), 256'(1));
    chk("wr_mem_addr",  256'(mem_addr),  256'(32'h8000_0020));
    for (int b = 0; b < 4; b++) begin
      chk("wr_mem_wdata", 256'(mem_wdata), 256'(wb[b]));
      chk("wr_no_mem_read", 256'(mem_read), 256'(0));
      mem_resp = 1'b1;
      tick();
    end
    chk("wr_line_resp", 256'(line_resp), 256'(1));
    chk("wr_mem_write_drop", 256'(mem_write), 256'(0));
    chk("wr_rdata_unchanged", line_rdata, exp_line);
    line_write = 1'b0; mem_resp = 1'b0;
    tick(); tick();
    chk("wr_single_resp", 256'(resp_cnt), 256'(1));

    // Simultaneous read and write: write wins
    line_read = 1'b1; line_write = 1'b1; line_addr = 32'h0000_0040;
    line_wdata = {wb[0], wb[1], wb[2], wb[3]};
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("rw_mem_write", 256'(mem_write), 256'(1));
      chk("rw_no_mem_read", 256'(mem_read), 256'(0));
      chk("rw_mem_wdata", 256'(mem_wdata), 256'(wb[3-b]));
      mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A; mem_resp = 1'b1;
      tick();
    end
    chk("rw_line_resp", 256'(line_resp), 256'(1));
    chk("rw_rdata_unchanged", line_rdata, exp_line);
    line_read = 1'b0; line_write = 1'b0; mem_resp = 1'b0;
    tick(); tick();

    // Async reset after two read beats
    resp_cnt = 0;
    line_read = 1'b1; line_addr = 32'h0000_2000;
    tick();
    for (int b = 0; b < 2; b++) begin
      mem_rdata = fb[b]; mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0; line_read = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_mem_read",   256'(mem_read),  256'(0));
    chk("arst_mem_addr",   256'(mem_addr),  256'(0));
    chk("arst_line_resp",  256'(line_resp), 256'(0));
    chk("arst_line_rdata", line_rdata, 256'(0));
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("arst_no_resp", 256'(resp_cnt), 256'(0));
    line_read = 1'b1; line_addr = 32'h0000_2010;
    tick();
    chk("arst_rd_addr", 256'(mem_addr), 256'(32'h0000_2000));
    for (int b = 0; b < 4; b++) begin
      mem_rdata = fb[b]; mem_resp = 1'b1;
      tick();
    end
    chk("arst_rd_resp", 256'(line_resp), 256'(1));
    chk("arst_rd_data", line_rdata, fresh_line);
    line_read = 1'b0; mem_resp = 1'b0;
    tick(); tick();

    // Back-to-back: request held one cycle past line_resp starts a second read
    resp_cnt = 0;
    line_read = 1'b1; line_addr = 32'h0000_3000;
    tick();
    for (int b = 0; b < 4; b++) begin
      mem_rdata = rb[b]; mem_resp = 1'b1;
      tick();
    end
    chk("b2b_first_resp", 256'(line_resp), 256'(1));
    mem_resp = 1'b0;
    tick();
    chk("b2b_idle_no_read", 256'(mem_read), 256'(0));
    chk("b2b_idle_no_resp", 256'(line_resp), 256'(0));
    tick();
    chk("b2b_second_read", 256'(mem_read), 256'(1));
    for (int b = 0; b < 4; b++) begin
      mem_rdata = fb[b]; mem_resp = 1'b1;
      tick();
    end
    chk("b2b_second_resp", 256'(line_resp), 256'(1));
    chk("b2b_second_data", line_rdata, fresh_line);
    line_read = 1'b0; mem_resp = 1'b0;
    tick(); tick();
    chk("b2b_resp_total", 256'(resp_cnt), 256'(2));
    chk("b2b_quiet", 256'({mem_read, mem_write, line_resp}), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
